// File: rtl/nibble_serial_addsub_if.sv
// Operation request/result bundle between the ALU controller and the nibble-serial add/sub unit.
interface nibble_serial_addsub_if;
   logic        start;
   logic        sub;
   logic        sat;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] Sum;
   logic        Z;
   logic        V;
   logic        N;

   modport master (
      output start, sub, sat, A, B,
      input  busy, done, Sum, Z, V, N
   );

   modport slave (
      input  start, sub, sat, A, B,
      output busy, done, Sum, Z, V, N
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// 16-bit add/subtract computed one nibble per cycle through a single 4-bit CLA,
// with optional signed saturation and Z/V/N flags behind a start/done handshake.
module cla_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [3:0] g, p;
   logic [4:0] c;

   always_comb begin
      g    = a_i & b_i;
      p    = a_i ^ b_i;
      c[0] = c_i;
      c[1] = g[0] | (p[0] & c_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c_i);
      s_o  = p ^ c[3:0];
      c_o  = c[4];
   end
endmodule

module nibble_serial_addsub #(
   parameter int unsigned NIB_COUNT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   nibble_serial_addsub_if.slave  bus
);
   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] beff_q, beff_d;
   logic [15:0] partial_q, partial_d;
   logic        carry_q, carry_d;
   logic        sat_q, sat_d;
   logic [1:0]  idx_q, idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] sum_q, sum_d;
   logic        z_q, z_d;
   logic        v_q, v_d;
   logic        n_q, n_d;

   logic [3:0]  cla_a, cla_b, cla_s;
   logic        cla_co;
   logic        ovf;
   logic [15:0] result;

   assign cla_a = a_q[{idx_q, 2'b00} +: 4];
   assign cla_b = beff_q[{idx_q, 2'b00} +: 4];

   cla_4bit u_cla (
      .a_i (cla_a),
      .b_i (cla_b),
      .c_i (carry_q),
      .s_o (cla_s),
      .c_o (cla_co)
   );

   // Overflow uses the effective (possibly inverted) B so subtraction needs no special case.
   assign ovf    = (a_q[15] == beff_q[15]) && (partial_q[15] != a_q[15]);
   assign result = (sat_q && ovf) ? (a_q[15] ? 16'h8000 : 16'h7FFF) : partial_q;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      beff_d    = beff_q;
      partial_d = partial_q;
      carry_d   = carry_q;
      sat_d     = sat_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sum_d     = sum_q;
      z_d       = z_q;
      v_d       = v_q;
      n_d       = n_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.A;
               beff_d  = bus.sub ? ~bus.B : bus.B;
               carry_d = bus.sub;
               sat_d   = bus.sat;
               idx_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            partial_d[{idx_q, 2'b00} +: 4] = cla_s;
            carry_d = cla_co;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'(NIB_COUNT - 1)) begin
               state_d = StFin;
            end
         end
         StFin: begin
            sum_d   = result;
            z_d     = (result == 16'h0000);
            v_d     = ovf;
            n_d     = result[15];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         a_q       <= '0;
         beff_q    <= '0;
         partial_q <= '0;
         carry_q   <= 1'b0;
         sat_q     <= 1'b0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sum_q     <= '0;
         z_q       <= 1'b0;
         v_q       <= 1'b0;
         n_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         beff_q    <= beff_d;
         partial_q <= partial_d;
         carry_q   <= carry_d;
         sat_q     <= sat_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sum_q     <= sum_d;
         z_q       <= z_d;
         v_q       <= v_d;
         n_q       <= n_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.Sum  = sum_q;
   assign bus.Z    = z_q;
   assign bus.V    = v_q;
   assign bus.N    = n_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench: a cycle model predicts busy/done and a signed-arithmetic golden model the result.
module tb_nibble_serial_addsub;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nibble_serial_addsub_if bus_if ();

   nibble_serial_addsub #(.NIB_COUNT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct packed {
      logic [15:0] sum;
      logic        z;
      logic        v;
      logic        n;
   } res_t;

   int   n_checks = 0;
   int   n_err    = 0;
   int   n_ops    = 0;
   bit   chk_en   = 1'b0;
   res_t exp_q[$];
   logic m_busy   = 1'b0;
   int   m_cnt    = 0;
   logic exp_done = 1'b0;
   res_t exp_out  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic res_t golden(input logic [15:0] a, input logic [15:0] b,
                                   input logic sb, input logic st);
      int   sa, sbv, full;
      logic ovf;
      logic [15:0] s;
      res_t r;
      sa   = $signed(a);
      sbv  = $signed(b);
      full = sb ? (sa - sbv) : (sa + sbv);
      ovf  = (full > 32767) || (full < -32768);
      if (ovf && st) s = (full > 0) ? 16'h7FFF : 16'h8000;
      else           s = full[15:0];
      r.sum = s;
      r.z   = (s == 16'h0000);
      r.v   = ovf;
      r.n   = s[15];
      return r;
   endfunction

   // Cycle model: updates on each edge, then compares all outputs just after it.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_busy   = 1'b0;
         m_cnt    = 0;
         exp_done = 1'b0;
         exp_out  = '0;
         chk_en   = 1'b1;
      end else begin
         exp_done = 1'b0;
         if (!m_busy) begin
            if (bus_if.start) begin
               exp_q.push_back(golden(bus_if.A, bus_if.B, bus_if.sub, bus_if.sat));
               m_busy = 1'b1;
               m_cnt  = 0;
            end
         end else begin
            m_cnt++;
            if (m_cnt == 5) begin
               m_busy   = 1'b0;
               exp_done = 1'b1;
               if (exp_q.size() == 0) check("sb_queue_empty", 32'd1, 32'd0);
               else exp_out = exp_q.pop_front();
               n_ops++;
            end
         end
      end
      #1;
      if (chk_en) begin
         check("busy", 32'(bus_if.busy), 32'(m_busy));
         check("done", 32'(bus_if.done), 32'(exp_done));
         check("sum",  32'(bus_if.Sum),  32'(exp_out.sum));
         check("z",    32'(bus_if.Z),    32'(exp_out.z));
         check("v",    32'(bus_if.V),    32'(exp_out.v));
         check("n",    32'(bus_if.N),    32'(exp_out.n));
      end
   end

   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sb, input logic st, input logic [15:0] e_sum,
                        input logic e_z, input logic e_v, input logic e_n);
      int   lat;
      logic found;
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.A     = a;
      bus_if.B     = b;
      bus_if.sub   = sb;
      bus_if.sat   = st;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.A     = 16'($urandom);
      bus_if.B     = 16'($urandom);
      bus_if.sub   = 1'($urandom);
      bus_if.sat   = 1'($urandom);
      lat   = 1;
      found = 1'b0;
      while (lat <= 10 && !found) begin
         @(posedge clk);
         #2;
         if (bus_if.done) found = 1'b1;
         else lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd5);
      check({tag, "_sum"}, 32'(bus_if.Sum), 32'(e_sum));
      check({tag, "_z"}, 32'(bus_if.Z), 32'(e_z));
      check({tag, "_v"}, 32'(bus_if.V), 32'(e_v));
      check({tag, "_n"}, 32'(bus_if.N), 32'(e_n));
   endtask

   initial begin
      int target;
      int cyc;
      rst          = 1'b1;
      bus_if.start = 1'b0;
      bus_if.sub   = 1'b0;
      bus_if.sat   = 1'b0;
      bus_if.A     = '0;
      bus_if.B     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_sum", 32'(bus_if.Sum), 32'd0);
      check("idle_busy", 32'(bus_if.busy), 32'd0);

      do_op("add_ff",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      do_op("add_fff",  16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      do_op("sub_eq",   16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      do_op("sub_neg",  16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);
      do_op("ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      do_op("ovf_satp", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      do_op("ovf_satn", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);

      // start held high with operands changing every cycle
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         bus_if.start = 1'b1;
         bus_if.A     = 16'($urandom);
         bus_if.B     = 16'($urandom);
         bus_if.sub   = 1'($urandom);
         bus_if.sat   = 1'($urandom);
      end
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (8) @(negedge clk);

      // start pulse while busy must be ignored
      bus_if.start = 1'b1;
      bus_if.A     = 16'h0001;
      bus_if.B     = 16'h0002;
      bus_if.sub   = 1'b0;
      bus_if.sat   = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.A     = 16'h4000;
      bus_if.B     = 16'h4000;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (5) @(negedge clk);
      check("ignore_sum", 32'(bus_if.Sum), 32'h0003);
      repeat (6) @(negedge clk);

      // reset lands on edge k+3 of an operation
      bus_if.start = 1'b1;
      bus_if.A     = 16'h1111;
      bus_if.B     = 16'h2222;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_sum", 32'(bus_if.Sum), 32'd0);
      check("midrst_busy", 32'(bus_if.busy), 32'd0);
      repeat (8) @(negedge clk);

      target = n_ops + 10000;
      cyc    = 0;
      while (n_ops < target && cyc < 80000) begin
         @(negedge clk);
         bus_if.start = ($urandom_range(0, 7) != 0);
         bus_if.A     = 16'($urandom);
         bus_if.B     = 16'($urandom);
         bus_if.sub   = 1'($urandom);
         bus_if.sat   = 1'($urandom);
         cyc++;
      end
      bus_if.start = 1'b0;
      if (n_ops < target) check("rand_timeout", 32'(n_ops), 32'(target));
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
